// File: rtl/univ_shift_seq_if.sv
// univ_shift_seq_if: command/data bundle between a controller and the shift sequencer
interface univ_shift_seq_if #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
);
    logic             start;
    logic [2:0]       mode;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] d;
    logic             i;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic             so;
    logic             busy;
    logic             done;
    modport master (output start, mode, amt, d, i, abort, input q, so, busy, done);
    modport slave  (input start, mode, amt, d, i, abort, output q, so, busy, done);
endinterface

// File: rtl/univ_shift_seq.sv
// univ_shift_seq: universal shift/rotate register that runs multi-step commands one step per cycle
module univ_shift_seq #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input logic            clk,
    input logic            nrst,
    univ_shift_seq_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    logic [0:0]       r_state;
    logic [AW-1:0]    r_rem;
    logic [2:0]       r_mode;
    logic [WIDTH-1:0] r_q;
    logic             r_so;
    logic             r_done;
    logic [WIDTH-1:0] w_step_q;
    logic             w_step_so;
    logic             w_seq_cmd;
    // single-step result for the latched mode; so gets the bit that leaves the register
    always_comb begin
        w_step_q  = r_q;
        w_step_so = r_so;
        case (r_mode)
            3'b010: begin w_step_q = {r_q[WIDTH-2:0], bus.i};      w_step_so = r_q[WIDTH-1]; end
            3'b011: begin w_step_q = {bus.i, r_q[WIDTH-1:1]};      w_step_so = r_q[0];       end
            3'b100: begin w_step_q = {r_q[WIDTH-2:0], r_q[WIDTH-1]}; w_step_so = r_q[WIDTH-1]; end
            3'b101: begin w_step_q = {r_q[0], r_q[WIDTH-1:1]};     w_step_so = r_q[0];       end
            3'b110: begin w_step_q = {r_q[WIDTH-1], r_q[WIDTH-1:1]}; w_step_so = r_q[0];     end
            default: ;
        endcase
    end
    assign w_seq_cmd = (bus.mode >= 3'b010) && (bus.mode != 3'b111);
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_mode  <= '0;
            r_q     <= '0;
            r_so    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (bus.start) begin
                    if (bus.mode == 3'b001) r_q <= bus.d;
                    if (w_seq_cmd && bus.amt != '0) begin
                        r_state <= RUN;
                        r_rem   <= bus.amt;
                        r_mode  <= bus.mode;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
            end else if (bus.abort) begin
                r_state <= IDLE;
                r_rem   <= '0;
            end else begin
                r_q   <= w_step_q;
                r_so  <= w_step_so;
                r_rem <= r_rem - AW'(1);
                if (r_rem == AW'(1)) begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end
    assign bus.q    = r_q;
    assign bus.so   = r_so;
    assign bus.busy = (r_state == RUN);
    assign bus.done = r_done;
endmodule

// File: tb/tb_univ_shift_seq.sv
// tb_univ_shift_seq: random and directed stimulus checked every cycle against an arithmetic model
module tb_univ_shift_seq;
    localparam int W  = 8;
    localparam int AW = $clog2(W) + 1;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    int checks = 0;
    int passes = 0;
    univ_shift_seq_if #(.WIDTH(W), .AW(AW)) bus ();
    univ_shift_seq #(.WIDTH(W), .AW(AW)) dut (.clk(clk), .nrst(nrst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [W-1:0] q;
        logic         so;
        bit           run;
        bit           done;
        int           rem;
        logic [2:0]   md;
    } ms_t;
    ms_t m;
    function automatic ms_t nxt(ms_t s, bit st, logic [2:0] md, int amt, logic [W-1:0] dd, bit ii, bit ab);
        ms_t n = s;
        bit up;
        n.done = 0;
        if (!s.run) begin
            if (st) begin
                if (md == 3'd1) begin n.q = dd; n.done = 1; end
                else if (md == 3'd0 || md == 3'd7 || amt == 0) n.done = 1;
                else begin n.run = 1; n.rem = amt; n.md = md; end
            end
        end else if (ab) begin
            n.run = 0;
        end else begin
            up = (s.md == 3'd2 || s.md == 3'd4);
            n.so = up ? s.q[W-1] : s.q[0];
            case (s.md)
                3'd2: n.q = (s.q << 1) | W'(ii);
                3'd3: n.q = (s.q >> 1) | (W'(ii) << (W-1));
                3'd4: n.q = (s.q << 1) | (s.q >> (W-1));
                3'd5: n.q = (s.q >> 1) | (s.q << (W-1));
                default: n.q = (s.q >> 1) | (s.q & (W'(1) << (W-1)));
            endcase
            n.rem = s.rem - 1;
            if (n.rem == 0) begin n.run = 0; n.done = 1; end
        end
        return n;
    endfunction
    always @(posedge clk or negedge nrst) begin
        if (!nrst) m <= '{q: '0, so: 1'b0, run: 0, done: 0, rem: 0, md: 3'd0};
        else m <= nxt(m, bus.start, bus.mode, int'(bus.amt), bus.d, bus.i, bus.abort);
    end
    always @(negedge clk) begin
        checks++;
        if ({bus.q, bus.so, bus.busy, bus.done} === {m.q, m.so, m.run, m.done}) passes++;
        else $display("FAIL cycle-check t=%0t q/so/busy/done got %h/%b/%b/%b want %h/%b/%b/%b",
                      $time, bus.q, bus.so, bus.busy, bus.done, m.q, m.so, m.run, m.done);
    end
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got %h want %h", nm, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic cmd(input logic [2:0] md, input logic [AW-1:0] a, input logic [W-1:0] dd, input logic ii);
        bus.start = 1'b1; bus.mode = md; bus.amt = a; bus.d = dd; bus.i = ii;
        tick();
        bus.start = 1'b0;
    endtask
    initial begin
        bus.start = 0; bus.mode = 0; bus.amt = 0; bus.d = 0; bus.i = 0; bus.abort = 0;
        #3;
        chk("reset_q", 32'(bus.q), 0);
        chk("reset_flags", {29'd0, bus.so, bus.busy, bus.done}, 0);
        #4 nrst = 1'b1;
        // load 0xA5 then shift-down 3 with i=1
        cmd(3'd1, 0, 8'hA5, 0);
        chk("load_q", 32'(bus.q), 32'hA5);
        chk("load_done", 32'(bus.done), 1);
        cmd(3'd3, 3, 8'h00, 1);
        chk("sd_accept_q", 32'(bus.q), 32'hA5);
        chk("sd_accept_busy", 32'(bus.busy), 1);
        tick(); chk("sd_s1", {23'd0, bus.so, bus.q}, {23'd0, 1'b1, 8'hD2});
        tick(); chk("sd_s2", {23'd0, bus.so, bus.q}, {23'd0, 1'b0, 8'hE9});
        chk("sd_busy3", 32'(bus.busy), 1);
        tick(); chk("sd_s3", {23'd0, bus.so, bus.q}, {23'd0, 1'b1, 8'hF4});
        chk("sd_end", {30'd0, bus.busy, bus.done}, 32'b01);
        // full rotate-up
        cmd(3'd1, 0, 8'h81, 0);
        cmd(3'd4, 8, 8'h00, 0);
        for (int k = 0; k < 7; k++) tick();
        chk("rot_busy7", 32'(bus.busy), 1);
        tick();
        chk("rot_q", 32'(bus.q), 32'h81);
        chk("rot_end", {30'd0, bus.busy, bus.done}, 32'b01);
        // arithmetic shift-down
        cmd(3'd1, 0, 8'h90, 0);
        cmd(3'd6, 2, 8'h00, 0);
        tick(); chk("asr_s1", {23'd0, bus.so, bus.q}, {23'd0, 1'b0, 8'hC8});
        tick(); chk("asr_s2", {23'd0, bus.so, bus.q}, {23'd0, 1'b0, 8'hE4});
        // start during RUN ignored, then amt=0 accepted in the done cycle
        cmd(3'd1, 0, 8'h3C, 0);
        cmd(3'd2, 2, 8'h00, 0);
        bus.start = 1; bus.mode = 3'd1; bus.d = 8'hFF;
        tick(); tick();
        chk("ign_q", 32'(bus.q), 32'hF0);
        chk("ign_done", 32'(bus.done), 1);
        cmd(3'd2, 0, 8'h00, 1);
        chk("zero_q", 32'(bus.q), 32'hF0);
        chk("zero_flags", {30'd0, bus.busy, bus.done}, 32'b01);
        tick();
        chk("zero_after", 32'(bus.done), 0);
        // abort after two steps
        cmd(3'd1, 0, 8'h01, 0);
        cmd(3'd2, 5, 8'h00, 0);
        tick(); tick();
        bus.abort = 1;
        tick();
        bus.abort = 0;
        chk("abort_q", 32'(bus.q), 32'h04);
        chk("abort_flags", {30'd0, bus.busy, bus.done}, 0);
        tick();
        chk("abort_nodone", 32'(bus.done), 0);
        // asynchronous reset mid-run
        cmd(3'd1, 0, 8'h0F, 0);
        cmd(3'd5, 6, 8'h00, 0);
        tick();
        nrst = 0;
        #1;
        chk("arst_q", 32'(bus.q), 0);
        chk("arst_flags", {29'd0, bus.so, bus.busy, bus.done}, 0);
        #4 nrst = 1;
        cmd(3'd1, 0, 8'h55, 0);
        cmd(3'd2, 1, 8'h00, 1);
        tick();
        chk("post_rst", {23'd0, bus.so, bus.q}, {23'd0, 1'b0, 8'hAB});
        // random phase
        for (int k = 0; k < 2000; k++) begin
            bus.start = ($urandom_range(0, 2) == 0);
            bus.mode  = 3'($urandom);
            bus.amt   = AW'($urandom);
            bus.d     = W'($urandom);
            bus.i     = 1'($urandom);
            bus.abort = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) begin
                nrst = 0;
                #1 nrst = 1;
            end
            tick();
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
